dvp_pattern_gen: RTL and testbench
==================================

Name: dvp_pattern_gen

Overview:
- Synthetic DVP camera source: drives VSYNC/HREF/10-bit PIXDATA with the same framing a sensor presents to the capture path.
- Sits on the sensor side of the DVP link and replaces the physical camera for board bring-up and frame-buffer verification.
- Output feeds the video-in port of the frame buffer directly; selectable RAW10 test patterns allow deterministic HDMI-side checks.

Parameters:
- H_ACTIVE, 640, active pixels per line (HREF high cycles); >=1.
- H_BLANK, 144, HREF-low cycles per line; >=1. H_TOTAL = H_ACTIVE + H_BLANK.
- V_SYNC, 3, lines with VSYNC asserted; >=1.
- V_BPORCH, 17, blank lines after VSYNC before first active line; >=1.
- V_ACTIVE, 480, active lines per frame; >=1.
- V_FPORCH, 10, blank lines after last active line; >=1.
- VS_POL, 0, VSYNC asserted level (0: low during sync, matching the frame buffer's vs_n input).

Ports:
- I_clk  input  1  pixel clock; all logic on rising edge.
- I_rst_n  input  1  asynchronous active-low reset.
- I_en  input  1  run request; sampled in IDLE and at frame end.
- I_mode  input  2  pattern select, latched at frame start.
- O_vsync  output  1  frame sync, asserted level = VS_POL.
- O_href  output  1  line-valid; high only for active pixels.
- O_pixdata  output  10  RAW10 pixel; 0 whenever O_href low.
- O_frame_cnt  output  16  completed frames, wraps 16'hFFFF->0.
- O_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE, h/v counters 0, O_vsync = ~VS_POL, O_href 0, O_pixdata 0, O_frame_cnt 0, O_busy 0, latched mode 0. Reset mid-frame aborts immediately, no partial-frame completion.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, VSYNC, VBP, ACTIVE, VFP. Each non-IDLE state lasts an integer number of lines; h counter runs 0..H_TOTAL-1 and wraps. v counter counts lines within the current state and is cleared on every state change.
- IDLE -> VSYNC on the clock edge at which I_en=1; I_mode latched on the same edge; h=0.
- VSYNC (V_SYNC lines) -> VBP (V_BPORCH lines) -> ACTIVE (V_ACTIVE lines) -> VFP (V_FPORCH lines). Each transition occurs on the edge where h=H_TOTAL-1 and the line count is complete.
- End of VFP (last cycle of last line): O_frame_cnt +1. If I_en=1, go directly to VSYNC with no idle gap and latch I_mode; else go to IDLE.
- I_en deassert mid-frame: the frame completes; IDLE is entered only at the end of VFP. I_mode changes mid-frame are ignored.
- O_vsync = VS_POL for exactly V_SYNC*H_TOTAL cycles per frame; ~VS_POL otherwise.
- O_href = 1 iff state=ACTIVE and h<H_ACTIVE. This gives exactly H_ACTIVE*V_ACTIVE high cycles per frame, in V_ACTIVE bursts of H_ACTIVE.
- x = h (0..H_ACTIVE-1); y = active line index (0..V_ACTIVE-1). Pixel values, truncated to 10 bits:
  - mode 0: x[9:0] (horizontal ramp)
  - mode 1: y[9:0] (vertical ramp)
  - mode 2: (x[3]^y[3]) ? 10'h3FF : 10'h000 (8x8 checkerboard)
  - mode 3: O_frame_cnt[9:0] (flat field, value = count at frame start)
- Latency: registered outputs appear 1 cycle after the counter state. O_href and O_pixdata are mutually aligned; O_vsync uses the same alignment.
- O_busy = 1 from the first VSYNC cycle through the last VFP cycle.
- Frame period = (V_SYNC+V_BPORCH+V_ACTIVE+V_FPORCH)*H_TOTAL cycles. Defaults: 510*784 = 399840.

Test Plan:
- All tests use H_ACTIVE=8, H_BLANK=4, V_SYNC=1, V_BPORCH=1, V_ACTIVE=4, V_FPORCH=1, VS_POL=0. Frame = 7 lines * 12 = 84 cycles.
- Reset then I_en=0 for 200 cycles -> O_vsync=1, O_href=0, O_pixdata=0, O_busy=0, O_frame_cnt=0 throughout.
- I_en=1 held, mode 0 -> O_vsync low 12 cycles; 4 HREF bursts of 8 with O_pixdata 0..7 each, spaced 12 cycles; frames back-to-back 84 cycles apart; O_frame_cnt 1,2,3.
- Mode 2 with H_ACTIVE=16, V_ACTIVE=16 -> pixel (x=8,y=0)=3FF, (x=8,y=8)=000, (x=0,y=8)=3FF.
- Mode 3 for 3 frames -> flat fields of 0, 1, 2. Switching I_mode 3->1 mid-frame takes effect only at the next frame; that frame shows O_pixdata = line index 0..3.
- Drop I_en during ACTIVE line 2 -> frame completes normally, O_frame_cnt +1, O_busy falls after the last VFP cycle, then IDLE.
- Assert I_rst_n=0 mid-ACTIVE -> outputs at reset values on the same cycle. Release with I_en=1 -> fresh frame starts with VSYNC and O_frame_cnt=0.

Source files
------------

// File: rtl/dvp_pattern_gen.sv
// Synthetic DVP sensor source: VSYNC/HREF framing with selectable RAW10 test patterns.
// Outputs registered one cycle behind the h/v counters; no backpressure (free-running pixel clock).
module dvp_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BPORCH = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FPORCH = 10,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_en,
    input  logic [1:0]  I_mode,
    output logic        O_vsync,
    output logic        O_href,
    output logic [9:0]  O_pixdata,
    output logic [15:0] O_frame_cnt,
    output logic        O_busy
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_M1    = (V_SYNC > V_BPORCH) ? V_SYNC : V_BPORCH;
    localparam int V_M2    = (V_ACTIVE > V_FPORCH) ? V_ACTIVE : V_FPORCH;
    localparam int V_MAX   = (V_M1 > V_M2) ? V_M1 : V_M2;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_MAX + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_SYNC - 1);
    localparam logic [VW-1:0] VBP_LAST = VW'(V_BPORCH - 1);
    localparam logic [VW-1:0] VA_LAST  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VFP_LAST = VW'(V_FPORCH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [9:0]    pix_q, pix_d;
    logic          busy_q, busy_d;

    logic          line_end;
    logic [9:0]    x10;
    logic [9:0]    y10;
    logic [9:0]    pattern;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        line_end    = (h_q == H_LAST);

        if (state_q == ST_IDLE) begin
            if (I_en) begin
                state_d = ST_VSYNC;
                h_d     = '0;
                v_d     = '0;
                mode_d  = I_mode;
            end
        end else begin
            h_d = line_end ? '0 : h_q + HW'(1);
            if (line_end) begin
                v_d = v_q + VW'(1);
                case (state_q)
                    ST_VSYNC: if (v_q == VS_LAST) begin
                        state_d = ST_VBP;
                        v_d     = '0;
                    end
                    ST_VBP: if (v_q == VBP_LAST) begin
                        state_d = ST_ACTIVE;
                        v_d     = '0;
                    end
                    ST_ACTIVE: if (v_q == VA_LAST) begin
                        state_d = ST_VFP;
                        v_d     = '0;
                    end
                    ST_VFP: if (v_q == VFP_LAST) begin
                        // Back-to-back frames when still enabled; mode only changes here.
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        v_d         = '0;
                        if (I_en) begin
                            state_d = ST_VSYNC;
                            mode_d  = I_mode;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        x10 = 10'(h_q);
        y10 = 10'(v_q);
        case (mode_q)
            2'd0:    pattern = x10;
            2'd1:    pattern = y10;
            2'd2:    pattern = (x10[3] ^ y10[3]) ? 10'h3FF : 10'h000;
            default: pattern = frame_cnt_q[9:0];
        endcase
        vsync_d = (state_q == ST_VSYNC) ? VS_POL : ~VS_POL;
        href_d  = (state_q == ST_ACTIVE) && (h_q < H_ACT);
        pix_d   = href_d ? pattern : 10'd0;
        busy_d  = (state_q != ST_IDLE);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= ST_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            mode_q      <= 2'd0;
            frame_cnt_q <= 16'd0;
            vsync_q     <= ~VS_POL;
            href_q      <= 1'b0;
            pix_q       <= 10'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            pix_q       <= pix_d;
            busy_q      <= busy_d;
        end
    end

    assign O_vsync     = vsync_q;
    assign O_href      = href_q;
    assign O_pixdata   = pix_q;
    assign O_frame_cnt = frame_cnt_q;
    assign O_busy      = busy_q;

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// Bench for dvp_pattern_gen: small-frame instance (8x4) plus a 16x16 checkerboard instance.
module tb_dvp_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [1:0]  mode_a, mode_b;
    logic        vs_a, href_a, busy_a, vs_b, href_b, busy_b;
    logic [9:0]  pix_a, pix_b;
    logic [15:0] fc_a_o, fc_b_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int cyc;

    localparam int FRAME_A = 7 * 12;
    localparam int FRAME_B = 19 * 20;

    always #5 clk = ~clk;

    dvp_pattern_gen #(.H_ACTIVE(8), .H_BLANK(4), .V_SYNC(1), .V_BPORCH(1),
                      .V_ACTIVE(4), .V_FPORCH(1), .VS_POL(1'b0)) u_a (
        .I_clk(clk), .I_rst_n(rst_n), .I_en(en_a), .I_mode(mode_a),
        .O_vsync(vs_a), .O_href(href_a), .O_pixdata(pix_a),
        .O_frame_cnt(fc_a_o), .O_busy(busy_a));

    dvp_pattern_gen #(.H_ACTIVE(16), .H_BLANK(4), .V_SYNC(1), .V_BPORCH(1),
                      .V_ACTIVE(16), .V_FPORCH(1), .VS_POL(1'b0)) u_b (
        .I_clk(clk), .I_rst_n(rst_n), .I_en(en_b), .I_mode(mode_b),
        .O_vsync(vs_b), .O_href(href_b), .O_pixdata(pix_b),
        .O_frame_cnt(fc_b_o), .O_busy(busy_b));

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {vsync, href, busy, pix} for a frame position given as a cycle offset.
    function automatic logic [12:0] model_out(input bit run, input int off, input logic [1:0] m,
                                              input logic [15:0] fc, input int ha, input int hb,
                                              input int vsn, input int vbp, input int va);
        int ht, line, h, y;
        logic vs, hr;
        logic [9:0] px;
        ht = ha + hb;
        line = off / ht;
        h = off % ht;
        y = line - vsn - vbp;
        vs = 1'b1;
        hr = 1'b0;
        px = 10'd0;
        if (run) begin
            vs = (line < vsn) ? 1'b0 : 1'b1;
            hr = (y >= 0) && (y < va) && (h < ha);
            if (hr) begin
                case (m)
                    2'd0:    px = 10'(h);
                    2'd1:    px = 10'(y);
                    2'd2:    px = ((((h >> 3) ^ (y >> 3)) & 1) != 0) ? 10'h3FF : 10'h000;
                    default: px = fc[9:0];
                endcase
            end
        end
        return {vs, hr, run, px};
    endfunction

    bit          run_a, run_b;
    int          off_a, off_b;
    logic [1:0]  ml_a, ml_b;
    logic [15:0] fc_a, fc_b;
    logic [12:0] exp_a, exp_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_a <= 1'b0; off_a <= 0; ml_a <= 2'd0; fc_a <= 16'd0;
            exp_a <= {1'b1, 1'b0, 1'b0, 10'd0};
        end else begin
            exp_a <= model_out(run_a, off_a, ml_a, fc_a, 8, 4, 1, 1, 4);
            if (!run_a) begin
                if (en_a) begin run_a <= 1'b1; off_a <= 0; ml_a <= mode_a; end
            end else if (off_a == FRAME_A - 1) begin
                fc_a <= fc_a + 16'd1;
                off_a <= 0;
                if (en_a) ml_a <= mode_a; else run_a <= 1'b0;
            end else begin
                off_a <= off_a + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_b <= 1'b0; off_b <= 0; ml_b <= 2'd0; fc_b <= 16'd0;
            exp_b <= {1'b1, 1'b0, 1'b0, 10'd0};
        end else begin
            exp_b <= model_out(run_b, off_b, ml_b, fc_b, 16, 4, 1, 1, 16);
            if (!run_b) begin
                if (en_b) begin run_b <= 1'b1; off_b <= 0; ml_b <= mode_b; end
            end else if (off_b == FRAME_B - 1) begin
                fc_b <= fc_b + 16'd1;
                off_b <= 0;
                if (en_b) ml_b <= mode_b; else run_b <= 1'b0;
            end else begin
                off_b <= off_b + 1;
            end
        end
    end

    int href_cnt_a = 0;
    int vslo_cnt_a = 0;
    bit cap_done = 1'b0;
    logic [9:0] cap_b[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_vsync", vs_a, exp_a[12]);
            check("a_href", href_a, exp_a[11]);
            check("a_busy", busy_a, exp_a[10]);
            check("a_pix", pix_a, exp_a[9:0]);
            check("a_frame_cnt", fc_a_o, fc_a);
            check("b_vsync", vs_b, exp_b[12]);
            check("b_href", href_b, exp_b[11]);
            check("b_busy", busy_b, exp_b[10]);
            check("b_pix", pix_b, exp_b[9:0]);
            check("b_frame_cnt", fc_b_o, fc_b);
        end
        href_cnt_a <= href_cnt_a + (href_a ? 1 : 0);
        vslo_cnt_a <= vslo_cnt_a + (vs_a ? 0 : 1);
        if (!cap_done && href_b) cap_b.push_back(pix_b);
        if (fc_b_o != 16'd0) cap_done <= 1'b1;
    end

    task automatic go(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
    endtask

    int h0, v0;

    initial begin
        rst_n = 1'b1; en_a = 1'b0; mode_a = 2'd0; en_b = 1'b0; mode_b = 2'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst_n = 1'b1;
        en_b = 1'b1; mode_b = 2'd2;
        repeat (200) @(negedge clk);
        #1;
        check("idle_vsync", vs_a, 1);
        check("idle_busy", busy_a, 0);
        check("idle_frame_cnt", fc_a_o, 0);
        check("idle_href", href_a, 0);

        @(negedge clk);
        cyc = 0;
        en_a = 1'b1; mode_a = 2'd0;
        #1;
        h0 = href_cnt_a; v0 = vslo_cnt_a;
        go(84);  check("fcnt_before_end", fc_a_o, 0);
        go(85);  check("fcnt_1", fc_a_o, 1);
        #1;
        check("href_cycles_frame", href_cnt_a - h0, 32);
        check("vsync_low_cycles", vslo_cnt_a - v0, 12);
        go(169); check("fcnt_2", fc_a_o, 2);
        go(253); check("fcnt_3", fc_a_o, 3);
        mode_a = 2'd3;
        go(451); mode_a = 2'd1;
        go(557); en_a = 1'b0;
        go(589); check("busy_last_vfp", busy_a, 1); check("fcnt_7", fc_a_o, 7);
        go(590); check("busy_after_end", busy_a, 0);
        go(600); en_a = 1'b1; mode_a = 2'd0;
        go(640);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_href", href_a, 0);
        check("rst_pix", pix_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_vsync", vs_a, 1);
        check("rst_fcnt", fc_a_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("restart_vsync", vs_a, 0);
        check("restart_busy", busy_a, 1);
        check("restart_fcnt", fc_a_o, 0);

        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) en_a = ~en_a;
            if ($urandom_range(0, 29) == 0) mode_a = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;

        check("cb_pixels", cap_b.size(), 256);
        if (cap_b.size() == 256) begin
            check("cb_x8_y0", cap_b[8], 10'h3FF);
            check("cb_x8_y8", cap_b[8 * 16 + 8], 10'h000);
            check("cb_x0_y8", cap_b[8 * 16], 10'h3FF);
            check("cb_x0_y0", cap_b[0], 10'h000);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
